// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-lite constants and FSM state encoding for the miniTB responder.
package minitb_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA_W = 2'd1,
    ST_DATA_R = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // NONSEQ and SEQ both start a transfer; IDLE and BUSY never do.
  function automatic logic is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/minitb_ahb_slave_mem.sv
// Word-addressed storage for the miniTB AHB responder: synchronous write,
// registered read (holds until the next read enable), synchronous clear.
module minitb_ahb_slave_mem #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [addrWidth-1:0] waddr,
  input  logic [dataWidth-1:0] wdata,
  input  logic                 re,
  input  logic [addrWidth-1:0] raddr,
  output logic [dataWidth-1:0] rdata
);

  localparam int Depth = 1 << addrWidth;

  logic [dataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/minitb_ahb_slave.sv
// AHB-lite responder for the miniTB master BFM: pipelined single transfers,
// write-to-read forwarding, optional data-phase wait states (MINITB_AHB_SLAVE_WAIT_EN).
module minitb_ahb_slave
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth   = 8,
  parameter int dataWidth   = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic [dataWidth-1:0] hrdata,
  output logic                 hready
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("WAIT_STATES must be in 0..15");
  end

  // state is the FSM observation point for bound checkers.
  state_t               state;
  state_t               state_nxt;
  logic [addrWidth-1:0] addr_q;
  logic                 write_q;
  logic                 capture;
  logic                 wait_done;
  logic                 mem_we;
  logic                 rd_en;
  logic [addrWidth-1:0] rd_addr;
  logic                 fwd_hit;
  logic                 fwd_q;
  logic [dataWidth-1:0] fwd_data_q;
  logic [dataWidth-1:0] mem_rdata;

`ifdef MINITB_AHB_SLAVE_WAIT_EN
  localparam bit HasWait = (WAIT_STATES != 0);
  logic [3:0] wait_cnt;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wait_cnt <= '0;
    end else if (capture) begin
      wait_cnt <= 4'(WAIT_STATES);
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign wait_done = (state == ST_WAIT) && (wait_cnt == 4'd1);
`else
  localparam bit HasWait = 1'b0;
  assign wait_done = 1'b0;
`endif

  assign capture = hready & is_active(htrans);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_q  <= haddr;
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (capture) begin
      if (HasWait) state_nxt = ST_WAIT;
      else         state_nxt = hwrite ? ST_DATA_W : ST_DATA_R;
    end else if (state == ST_WAIT) begin
      if (wait_done) state_nxt = write_q ? ST_DATA_W : ST_DATA_R;
      else           state_nxt = ST_WAIT;
    end
  end

  // With wait states the read is fetched entering the last data cycle, so
  // the preceding write has already landed and no bypass is needed.
  always_comb begin
    hready = !(HasWait && (state == ST_WAIT));
    mem_we = (state == ST_DATA_W) && hready;
    if (HasWait) begin
      rd_en   = wait_done && !write_q;
      rd_addr = addr_q;
    end else begin
      rd_en   = capture && !hwrite;
      rd_addr = haddr;
    end
    fwd_hit = rd_en && !HasWait && (state == ST_DATA_W) && write_q && (haddr == addr_q);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (rd_en) begin
      fwd_q      <= fwd_hit;
      fwd_data_q <= hwdata;
    end
  end

  assign hrdata = fwd_q ? fwd_data_q : mem_rdata;

  minitb_ahb_slave_mem #(
    .addrWidth (addrWidth),
    .dataWidth (dataWidth)
  ) u_mem (
    .clk   (hclk),
    .rst   (hreset),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (hwdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Directed bench for minitb_ahb_slave; adds wait-state checks when
// MINITB_AHB_SLAVE_WAIT_EN is defined (WAIT_STATES=2).
module tb_minitb_ahb_slave;
  import minitb_ahb_pkg::*;

  logic        hclk;
  logic        hreset;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;

  int checks = 0;
  int errors = 0;

  minitb_ahb_slave #(
    .addrWidth   (8),
    .dataWidth   (32),
    .WAIT_STATES (2)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .htrans (htrans),
    .haddr  (haddr),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hready (hready)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the first posedge at which hready is high (transfer edge).
  task automatic wait_ready_edge(input string tag);
    logic rdy;
    int   n;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 40) begin
      @(negedge hclk);
      rdy = hready;
      @(posedge hclk);
      #1;
      n++;
    end
    if (!rdy) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called just after the read address was captured: check hrdata in the
  // completing data cycle and step past it.
  task automatic read_data_phase(input logic [31:0] exp, input string tag);
    logic rdy;
    int   n;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 40) begin
      @(negedge hclk);
      rdy = hready;
      if (!rdy) begin
        @(posedge hclk);
        #1;
        n++;
      end
    end
    if (rdy) check_eq(tag, hrdata, exp);
    else     check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge hclk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input string tag);
    htrans = HTRANS_NONSEQ;
    haddr  = a;
    hwrite = 1'b1;
    wait_ready_edge({tag, "_addr"});
    htrans = HTRANS_IDLE;
    hwdata = d;
    wait_ready_edge({tag, "_data"});
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    htrans = HTRANS_NONSEQ;
    haddr  = a;
    hwrite = 1'b0;
    wait_ready_edge({tag, "_addr"});
    htrans = HTRANS_IDLE;
    read_data_phase(exp, tag);
  endtask

  initial begin
    hreset = 1'b1;
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hwdata = '0;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;

    // Reset state held through idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      check_eq($sformatf("idle%0d_hready", i), {31'd0, hready}, 32'd1);
      check_eq($sformatf("idle%0d_hrdata", i), hrdata, 32'd0);
      @(posedge hclk);
      #1;
    end
    do_read(8'h00, 32'h0, "rd_reset_00");

    // Basic write, idle, read, then hrdata holds across idle and other writes.
    do_write(8'h10, 32'hDEADBEEF, "wr_10");
    @(posedge hclk);
    #1;
    do_read(8'h10, 32'hDEADBEEF, "rd_10");
    do_write(8'h11, 32'h01020304, "wr_11");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check_eq("hold_10", hrdata, 32'hDEADBEEF);
    @(posedge hclk);
    #1;

    // Back-to-back write then read of the same word: forwarded data.
    htrans = HTRANS_NONSEQ;
    haddr  = 8'h22;
    hwrite = 1'b1;
    wait_ready_edge("b2b_w_addr");
    hwdata = 32'h12345678;
    htrans = HTRANS_NONSEQ;
    haddr  = 8'h22;
    hwrite = 1'b0;
    wait_ready_edge("b2b_r_addr");
    htrans = HTRANS_IDLE;
    read_data_phase(32'h12345678, "b2b_fwd_22");
    do_read(8'h22, 32'h12345678, "rd_22_later");
    do_read(8'h11, 32'h01020304, "rd_11");

    // Address extremes and an untouched neighbour.
    do_write(8'h00, 32'hA5A5A5A5, "wr_00");
    do_write(8'hFF, 32'h5A5A5A5A, "wr_ff");
    do_read(8'h00, 32'hA5A5A5A5, "rd_00");
    do_read(8'hFE, 32'h00000000, "rd_fe");
    do_read(8'hFF, 32'h5A5A5A5A, "rd_ff");

    // Reset in the data phase of a write drops the write and clears memory.
    htrans = HTRANS_NONSEQ;
    haddr  = 8'h30;
    hwrite = 1'b1;
    wait_ready_edge("rst_w_addr");
    htrans = HTRANS_IDLE;
    hwdata = 32'hCAFEF00D;
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("rst_hready", {31'd0, hready}, 32'd1);
    check_eq("rst_hrdata", hrdata, 32'd0);
    @(posedge hclk);
    #1;
    do_read(8'h30, 32'h0, "rd_30_after_rst");
    do_read(8'h10, 32'h0, "rd_10_after_rst");

`ifdef MINITB_AHB_SLAVE_WAIT_EN
    do_write(8'h40, 32'h40404040, "w_wr_40");
    htrans = HTRANS_NONSEQ;
    haddr  = 8'h40;
    hwrite = 1'b0;
    @(negedge hclk);
    check_eq("w_rd40_addr_rdy", {31'd0, hready}, 32'd1);
    @(posedge hclk);
    #1;
    // Next transfer presented while stalled; it must wait for hready.
    haddr  = 8'h41;
    hwrite = 1'b1;
    @(negedge hclk);
    check_eq("w_rd40_stall1", {31'd0, hready}, 32'd0);
    @(posedge hclk);
    #1;
    @(negedge hclk);
    check_eq("w_rd40_stall2", {31'd0, hready}, 32'd0);
    @(posedge hclk);
    #1;
    @(negedge hclk);
    check_eq("w_rd40_final_rdy", {31'd0, hready}, 32'd1);
    check_eq("w_rd40_data", hrdata, 32'h40404040);
    @(posedge hclk);
    #1;
    htrans = HTRANS_IDLE;
    hwdata = 32'h41414141;
    @(negedge hclk);
    check_eq("w_wr41_stall1", {31'd0, hready}, 32'd0);
    @(posedge hclk);
    #1;
    @(negedge hclk);
    check_eq("w_wr41_stall2", {31'd0, hready}, 32'd0);
    @(posedge hclk);
    #1;
    @(negedge hclk);
    check_eq("w_wr41_final_rdy", {31'd0, hready}, 32'd1);
    @(posedge hclk);
    #1;
    do_read(8'h41, 32'h41414141, "w_rd_41");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minitb_ahb_slave.md
Name: minitb_ahb_slave

Overview:
Synthesizable AHB-lite responder (slave) forming the far end of the miniTB AHB master BFM. It has a word-addressed memory of 2**addrWidth entries and supports single NONSEQ reads and writes, including back-to-back pipelined transfers. Unit tests wire it straight to the master's htrans/haddr/hwrite/hwdata/hrdata/hready nets.

Parameters:
addrWidth, 8, haddr width; memory depth = 2**addrWidth words
dataWidth, 32, hwdata/hrdata width
WAIT_STATES, 2, data-phase wait cycles per transfer; used only when MINITB_AHB_SLAVE_WAIT_EN is defined; legal range 0..15

Ports:
hclk  input  1  clock; all logic on posedge
hreset  input  1  synchronous, active-high reset
htrans  input  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
haddr  input  addrWidth  transfer address
hwrite  input  1  1=write, 0=read; sampled with haddr
hwdata  input  dataWidth  write data, valid in data phase
hrdata  output  dataWidth  read data, valid in data phase while hready=1
hready  output  1  1=transfer completes this cycle; 0=stall

Behaviour:
- Interface: one clock hclk; reset hreset is synchronous and active-high.
- Reset (posedge hclk with hreset=1): hready=1, hrdata=0, state=IDLE, all memory words=0, pending-address register=0. Reset overrides any transfer in progress. A half-done write is dropped.
- Address-phase capture happens on posedge when hready=1 and htrans[1]=1 (NONSEQ or SEQ; SEQ is treated as NONSEQ). IDLE and BUSY are never captured.
- On capture, latch addr_q=haddr and write_q=hwrite, then enter DATA_W or DATA_R.
- States:
  - IDLE: no data phase pending.
  - DATA_W / DATA_R: data phase of the captured transfer.
  - WAIT: only exists with the wait feature.
- Write: at the posedge ending DATA_W with hready=1, store mem[addr_q]=hwdata. Data is visible to a read captured at any later posedge.
- Read: at the capture posedge, register hrdata=mem[haddr]. hrdata is valid for the whole DATA_R cycle (zero-wait latency = 1 cycle after address). hrdata holds its value until the next read capture.
- Pipelining: a new address may be captured at the same posedge that ends the current data phase. The state goes directly DATA_x to DATA_y, with no idle cycle.
- Hazard: if a read is captured at the posedge that commits a write (write_q=1) and haddr==addr_q, hrdata takes hwdata (forwarding), not the stale memory word.
- After a data phase, an IDLE/BUSY htrans returns state to IDLE. hrdata is unchanged.
- Address is an index, not a byte address: no wrap logic is needed since all 2**addrWidth values are legal. hsize/hburst/hresp are not implemented; the response is always OKAY.

Optional Feature:
- Macro: MINITB_AHB_SLAVE_WAIT_EN.
- Defined:
  - Each data phase lasts WAIT_STATES+1 cycles, with hready=0 for the first WAIT_STATES cycles (state WAIT, 4-bit down-counter loaded at capture).
  - While hready=0, no address is captured and memory is not written. The master must hold its signals.
  - Reads fetch mem[addr_q] on the posedge entering the final cycle, so forwarding is unnecessary. WAIT_STATES=0 behaves exactly as undefined.
- Undefined: hready is held at 1 after reset, and the WAIT state and counter are not built.

Decomposition:
- Package minitb_ahb_pkg: htrans constants IDLE/BUSY/NONSEQ/SEQ, and the state enum (IDLE, DATA_W, DATA_R, WAIT).
- Sub-module minitb_ahb_slave_mem: single-port-write, single-port-read array with synchronous write and read, plus the reset-clear. The top holds the FSM, forwarding and the wait counter.

Test Plan:
- Reset, then hold htrans=IDLE for 5 cycles -> hready=1 and hrdata=0 throughout; no memory change (read of 0x00 returns 0).
- basic_write(0x10, 0xDEADBEEF), idle, basic_read(0x10) -> hrdata=0xDEADBEEF in the read data phase.
- Back-to-back basic_write(0x22, 0x12345678) then basic_read(0x22) with no idle between -> forwarding returns 0x12345678.
- Writes to 0x00 and 0xFF (=0xA5A5A5A5, 0x5A5A5A5A), then reads of both -> correct values; the neighbour at 0xFE stays 0.
- Assert hreset during the data phase of a write to 0x30 -> a later read of 0x30 returns 0; hready=1 and hrdata=0 after reset.
- With MINITB_AHB_SLAVE_WAIT_EN and WAIT_STATES=2:
  - A read of a preloaded 0x40 gives hready=0 for 2 cycles, then 1, with hrdata valid in that cycle.
  - A stalled NONSEQ to 0x41 is captured only after hready rises.
